// File: rtl/reservation_station_array_if.sv
`default_nettype none
// ============================================================================
//  Module   : reservation_station_array_if
//  Desc     : Dispatch / CDB / issue bundle for the reservation station.
//             master = rename/dispatch + CDB + execution-unit side,
//             slave  = the reservation station itself.
//  Revision : 1.0  initial release
// ============================================================================
interface reservation_station_array_if #(
    parameter int NUM_ENTRIES = 4,
    parameter int TAG_WIDTH   = 7,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_CDB     = 2
) ();
    logic                            flush;
    logic                            disp_valid;
    logic                            disp_ready;
    logic [31:0]                     disp_instr;
    logic [TAG_WIDTH-1:0]            disp_rd;
    logic [TAG_WIDTH-1:0]            disp_rs1_tag;
    logic                            disp_rs1_ready;
    logic [DATA_WIDTH-1:0]           disp_rs1_data;
    logic [TAG_WIDTH-1:0]            disp_rs2_tag;
    logic                            disp_rs2_ready;
    logic [DATA_WIDTH-1:0]           disp_rs2_data;
    logic [NUM_CDB-1:0]              cdb_valid;
    logic [NUM_CDB*TAG_WIDTH-1:0]    cdb_tag;
    logic [NUM_CDB*DATA_WIDTH-1:0]   cdb_data;
    logic                            issue_valid;
    logic                            issue_ready;
    logic [31:0]                     issue_instr;
    logic [TAG_WIDTH-1:0]            issue_rd;
    logic [DATA_WIDTH-1:0]           issue_rs1_data;
    logic [DATA_WIDTH-1:0]           issue_rs2_data;
    logic [$clog2(NUM_ENTRIES+1)-1:0] occupancy;

    modport master (
        output flush, disp_valid, disp_instr, disp_rd,
               disp_rs1_tag, disp_rs1_ready, disp_rs1_data,
               disp_rs2_tag, disp_rs2_ready, disp_rs2_data,
               cdb_valid, cdb_tag, cdb_data, issue_ready,
        input  disp_ready, issue_valid, issue_instr, issue_rd,
               issue_rs1_data, issue_rs2_data, occupancy
    );

    modport slave (
        input  flush, disp_valid, disp_instr, disp_rd,
               disp_rs1_tag, disp_rs1_ready, disp_rs1_data,
               disp_rs2_tag, disp_rs2_ready, disp_rs2_data,
               cdb_valid, cdb_tag, cdb_data, issue_ready,
        output disp_ready, issue_valid, issue_instr, issue_rd,
               issue_rs1_data, issue_rs2_data, occupancy
    );
endinterface
`default_nettype wire

// File: rtl/reservation_station_array.sv
`default_nettype none
// ============================================================================
//  Module   : reservation_station_array
//  Desc     : NUM_ENTRIES-deep reservation station. Captures operands from
//             NUM_CDB broadcast channels and issues the lowest-index ready
//             entry each cycle over a valid/ready handshake.
//             Optional macro RS_CDB_BYPASS_EN: operands dispatched not-ready
//             may capture a same-cycle CDB broadcast.
//  Revision : 1.0  initial release
// ============================================================================
module reservation_station_array #(
    parameter int NUM_ENTRIES = 4,
    parameter int TAG_WIDTH   = 7,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_CDB     = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    reservation_station_array_if.slave   bus
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int OCC_W = $clog2(NUM_ENTRIES + 1);

    logic [NUM_ENTRIES-1:0]  r_valid;
    logic [31:0]             r_instr    [NUM_ENTRIES];
    logic [TAG_WIDTH-1:0]    r_rd       [NUM_ENTRIES];
    logic [TAG_WIDTH-1:0]    r_rs1_tag  [NUM_ENTRIES];
    logic [TAG_WIDTH-1:0]    r_rs2_tag  [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0]  r_rs1_rdy;
    logic [NUM_ENTRIES-1:0]  r_rs2_rdy;
    logic [DATA_WIDTH-1:0]   r_rs1_data [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0]   r_rs2_data [NUM_ENTRIES];
    logic [OCC_W-1:0]        r_occ;

    logic                    w_alloc_found;
    logic [IDX_W-1:0]        w_alloc_idx;
    logic                    w_iss_found;
    logic [IDX_W-1:0]        w_iss_idx;
    logic                    w_disp_fire;
    logic                    w_issue_fire;
    logic [DATA_WIDTH:0]     w_wk1 [NUM_ENTRIES];   // {hit, data}
    logic [DATA_WIDTH:0]     w_wk2 [NUM_ENTRIES];
    logic [DATA_WIDTH:0]     w_byp1;
    logic [DATA_WIDTH:0]     w_byp2;

    // Returns {hit, data} of the lowest-numbered valid CDB channel carrying tag.
    function automatic logic [DATA_WIDTH:0] cdb_match(
        input logic [TAG_WIDTH-1:0]          tag,
        input logic [NUM_CDB-1:0]            vld,
        input logic [NUM_CDB*TAG_WIDTH-1:0]  tags,
        input logic [NUM_CDB*DATA_WIDTH-1:0] data
    );
        logic [DATA_WIDTH:0] res;
        res = '0;
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (vld[c] && tags[c*TAG_WIDTH +: TAG_WIDTH] == tag)
                res = {1'b1, data[c*DATA_WIDTH +: DATA_WIDTH]};
        end
        return res;
    endfunction

    // Lowest free slot for dispatch and lowest fully-ready slot for issue.
    always_comb begin
        w_alloc_found = 1'b0;
        w_alloc_idx   = '0;
        w_iss_found   = 1'b0;
        w_iss_idx     = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_alloc_found = 1'b1;
                w_alloc_idx   = IDX_W'(i);
            end
            if (r_valid[i] && r_rs1_rdy[i] && r_rs2_rdy[i]) begin
                w_iss_found = 1'b1;
                w_iss_idx   = IDX_W'(i);
            end
        end
    end

    // CDB tag match for every waiting operand, plus the optional dispatch bypass.
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_wk1[i] = cdb_match(r_rs1_tag[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
            w_wk2[i] = cdb_match(r_rs2_tag[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        end
`ifdef RS_CDB_BYPASS_EN
        w_byp1 = cdb_match(bus.disp_rs1_tag, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        w_byp2 = cdb_match(bus.disp_rs2_tag, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
`else
        w_byp1 = '0;
        w_byp2 = '0;
`endif
    end

    assign bus.disp_ready  = w_alloc_found;
    assign bus.issue_valid = w_iss_found && !bus.flush;
    assign bus.occupancy   = r_occ;
    assign w_disp_fire     = bus.disp_valid && w_alloc_found && !bus.flush;
    assign w_issue_fire    = bus.issue_valid && bus.issue_ready;

    // Issue payload of the selected entry; zero when nothing is selectable.
    always_comb begin
        bus.issue_instr    = '0;
        bus.issue_rd       = '0;
        bus.issue_rs1_data = '0;
        bus.issue_rs2_data = '0;
        if (w_iss_found) begin
            bus.issue_instr    = r_instr[w_iss_idx];
            bus.issue_rd       = r_rd[w_iss_idx];
            bus.issue_rs1_data = r_rs1_data[w_iss_idx];
            bus.issue_rs2_data = r_rs2_data[w_iss_idx];
        end
    end

    // Entry valid bits: flush wins; issue and dispatch never target the same slot.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
        end else if (bus.flush) begin
            r_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (w_issue_fire && w_iss_idx == IDX_W'(i))
                    r_valid[i] <= 1'b0;
                if (w_disp_fire && w_alloc_idx == IDX_W'(i))
                    r_valid[i] <= 1'b1;
            end
        end
    end

    // Occupancy counter tracks dispatch minus issue.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_occ <= '0;
        else if (bus.flush)
            r_occ <= '0;
        else
            r_occ <= r_occ + OCC_W'(w_disp_fire) - OCC_W'(w_issue_fire);
    end

    // Payload: dispatch writes a free slot; wakeup fills waiting operands of valid slots.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (w_disp_fire && w_alloc_idx == IDX_W'(i)) begin
                r_instr[i]    <= bus.disp_instr;
                r_rd[i]       <= bus.disp_rd;
                r_rs1_tag[i]  <= bus.disp_rs1_tag;
                r_rs2_tag[i]  <= bus.disp_rs2_tag;
                r_rs1_rdy[i]  <= bus.disp_rs1_ready || w_byp1[DATA_WIDTH];
                r_rs2_rdy[i]  <= bus.disp_rs2_ready || w_byp2[DATA_WIDTH];
                r_rs1_data[i] <= bus.disp_rs1_ready ? bus.disp_rs1_data : w_byp1[DATA_WIDTH-1:0];
                r_rs2_data[i] <= bus.disp_rs2_ready ? bus.disp_rs2_data : w_byp2[DATA_WIDTH-1:0];
            end else if (r_valid[i] && !bus.flush) begin
                if (!r_rs1_rdy[i] && w_wk1[i][DATA_WIDTH]) begin
                    r_rs1_rdy[i]  <= 1'b1;
                    r_rs1_data[i] <= w_wk1[i][DATA_WIDTH-1:0];
                end
                if (!r_rs2_rdy[i] && w_wk2[i][DATA_WIDTH]) begin
                    r_rs2_rdy[i]  <= 1'b1;
                    r_rs2_data[i] <= w_wk2[i][DATA_WIDTH-1:0];
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_reservation_station_array.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reservation_station_array
//  Desc     : Directed + randomized bench for reservation_station_array,
//             checked against an entry-list reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reservation_station_array;
    localparam int NE = 4;
    localparam int TW = 7;
    localparam int DW = 32;
    localparam int NC = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    reservation_station_array_if #(.NUM_ENTRIES(NE), .TAG_WIDTH(TW),
                                   .DATA_WIDTH(DW), .NUM_CDB(NC)) bus ();

    reservation_station_array #(.NUM_ENTRIES(NE), .TAG_WIDTH(TW),
                                .DATA_WIDTH(DW), .NUM_CDB(NC)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit            v;
        logic [31:0]   instr;
        logic [TW-1:0] rd;
        logic [TW-1:0] t1, t2;
        bit            r1, r2;
        logic [DW-1:0] d1, d2;
    } ent_t;

    ent_t m[NE];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NE; i++) m[i].v = 1'b0;
    endtask

    task automatic idle();
        bus.flush = 0; bus.disp_valid = 0; bus.disp_instr = '0; bus.disp_rd = '0;
        bus.disp_rs1_tag = '0; bus.disp_rs1_ready = 0; bus.disp_rs1_data = '0;
        bus.disp_rs2_tag = '0; bus.disp_rs2_ready = 0; bus.disp_rs2_data = '0;
        bus.cdb_valid = '0; bus.cdb_tag = '0; bus.cdb_data = '0; bus.issue_ready = 0;
    endtask

    task automatic disp(input logic [31:0] instr, input logic [TW-1:0] rd,
                        input logic [TW-1:0] t1, input bit r1, input logic [DW-1:0] d1,
                        input logic [TW-1:0] t2, input bit r2, input logic [DW-1:0] d2);
        bus.disp_valid = 1; bus.disp_instr = instr; bus.disp_rd = rd;
        bus.disp_rs1_tag = t1; bus.disp_rs1_ready = r1; bus.disp_rs1_data = d1;
        bus.disp_rs2_tag = t2; bus.disp_rs2_ready = r2; bus.disp_rs2_data = d2;
    endtask

    task automatic cdb(input int c, input logic [TW-1:0] t, input logic [DW-1:0] d);
        bus.cdb_valid[c] = 1'b1;
        bus.cdb_tag[c*TW +: TW] = t;
        bus.cdb_data[c*DW +: DW] = d;
    endtask

    // Lowest valid channel carrying tag t.
    function automatic bit cdb_lookup(input logic [TW-1:0] t, output logic [DW-1:0] d);
        d = '0;
        for (int c = 0; c < NC; c++) begin
            if (bus.cdb_valid[c] && bus.cdb_tag[c*TW +: TW] == t) begin
                d = bus.cdb_data[c*DW +: DW];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // One clock: check outputs at negedge against model, then advance model.
    task automatic cycle();
        int            sel, free, cnt;
        bit            exp_iv;
        logic [DW-1:0] d;
        ent_t          nx[NE];
        @(negedge clock);
        sel = -1; free = -1; cnt = 0;
        for (int i = 0; i < NE; i++) begin
            if (m[i].v) begin
                cnt++;
                if (sel < 0 && m[i].r1 && m[i].r2) sel = i;
            end else if (free < 0) begin
                free = i;
            end
        end
        exp_iv = (sel >= 0) && !bus.flush;
        chk("disp_ready", 64'(bus.disp_ready), 64'(cnt < NE));
        chk("occupancy", 64'(bus.occupancy), 64'(cnt));
        chk("issue_valid", 64'(bus.issue_valid), 64'(exp_iv));
        if (exp_iv) begin
            chk("issue_instr", 64'(bus.issue_instr), 64'(m[sel].instr));
            chk("issue_rd", 64'(bus.issue_rd), 64'(m[sel].rd));
            chk("issue_rs1", 64'(bus.issue_rs1_data), 64'(m[sel].d1));
            chk("issue_rs2", 64'(bus.issue_rs2_data), 64'(m[sel].d2));
        end
        nx = m;
        if (bus.flush) begin
            for (int i = 0; i < NE; i++) nx[i].v = 1'b0;
        end else begin
            if (exp_iv && bus.issue_ready) nx[sel].v = 1'b0;
            for (int i = 0; i < NE; i++) begin
                if (m[i].v) begin
                    if (!m[i].r1 && cdb_lookup(m[i].t1, d)) begin nx[i].r1 = 1; nx[i].d1 = d; end
                    if (!m[i].r2 && cdb_lookup(m[i].t2, d)) begin nx[i].r2 = 1; nx[i].d2 = d; end
                end
            end
            if (bus.disp_valid && free >= 0) begin
                nx[free].v = 1; nx[free].instr = bus.disp_instr; nx[free].rd = bus.disp_rd;
                nx[free].t1 = bus.disp_rs1_tag; nx[free].t2 = bus.disp_rs2_tag;
                nx[free].r1 = bus.disp_rs1_ready; nx[free].d1 = bus.disp_rs1_data;
                nx[free].r2 = bus.disp_rs2_ready; nx[free].d2 = bus.disp_rs2_data;
`ifdef RS_CDB_BYPASS_EN
                if (!nx[free].r1 && cdb_lookup(nx[free].t1, d)) begin nx[free].r1 = 1; nx[free].d1 = d; end
                if (!nx[free].r2 && cdb_lookup(nx[free].t2, d)) begin nx[free].r2 = 1; nx[free].d2 = d; end
`endif
            end
        end
        @(posedge clock);
        #1;
        m = nx;
    endtask

    initial begin
        idle();
        model_clear();
        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst_disp_ready", 64'(bus.disp_ready), 64'd1);
        chk("rst_issue_valid", 64'(bus.issue_valid), 64'd0);
        chk("rst_occupancy", 64'(bus.occupancy), 64'd0);
        chk("rst_issue_instr", 64'(bus.issue_instr), 64'd0);
        chk("rst_issue_rs1", 64'(bus.issue_rs1_data), 64'd0);
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;

        // Fill the station, then hold a 5th dispatch while full
        for (int i = 0; i < NE; i++) begin
            disp(32'hC0 + 32'(i), TW'(i + 1), 7'h01, 1, 32'h100 + 32'(i), 7'h02, 1, 32'h200 + 32'(i));
            cycle();
        end
        disp(32'hFF, 7'h7F, 7'h01, 1, 32'h1, 7'h02, 1, 32'h2);
        cycle(); cycle();
        chk("full_occupancy", 64'(bus.occupancy), 64'd4);
        // Issue and dispatch in the same cycle while full: only issue fires
        bus.issue_ready = 1;
        cycle();
        chk("full_issue_occ", 64'(bus.occupancy), 64'd3);
        bus.issue_ready = 0;
        cycle();
        chk("refill_occ", 64'(bus.occupancy), 64'd4);
        // Down to 3 entries, then flush with a concurrent dispatch
        idle(); bus.issue_ready = 1; cycle();
        idle(); bus.flush = 1; disp(32'hEE, 7'h10, 7'h01, 1, 32'h0, 7'h02, 1, 32'h0);
        #1;
        chk("flush_issue_valid", 64'(bus.issue_valid), 64'd0);
        cycle();
        idle(); #1;
        chk("flush_occ", 64'(bus.occupancy), 64'd0);

        // CDB wakeup of rs1
        disp(32'hA0, 7'h03, 7'h12, 0, 32'h0, 7'h13, 1, 32'h77); cycle();
        idle(); cdb(0, 7'h12, 32'hDEADBEEF); cycle();
        idle(); #1;
        chk("wake_issue_valid", 64'(bus.issue_valid), 64'd1);
        chk("wake_rs1", 64'(bus.issue_rs1_data), 64'hDEADBEEF);
        bus.issue_ready = 1; cycle();

        // Two channels matching: channel 0 wins
        idle(); disp(32'hA1, 7'h04, 7'h01, 1, 32'h9, 7'h05, 0, 32'h0); cycle();
        idle(); cdb(0, 7'h05, 32'h1111); cdb(1, 7'h05, 32'h2222); cycle();
        idle(); #1;
        chk("prio_rs2", 64'(bus.issue_rs2_data), 64'h1111);
        bus.issue_ready = 1; cycle();

        // Entries 1 and 3 ready, stalled then drained in order
        idle();
        disp(32'hB0, 7'h01, 7'h30, 0, 32'h0, 7'h01, 1, 32'h0); cycle();
        disp(32'hB1, 7'h02, 7'h01, 1, 32'h11, 7'h01, 1, 32'h12); cycle();
        disp(32'hB2, 7'h03, 7'h31, 0, 32'h0, 7'h01, 1, 32'h0); cycle();
        disp(32'hB3, 7'h04, 7'h01, 1, 32'h31, 7'h01, 1, 32'h32); cycle();
        idle(); cycle(); cycle(); cycle();
        chk("stall_instr", 64'(bus.issue_instr), 64'hB1);
        bus.issue_ready = 1; cycle();
        chk("next_instr", 64'(bus.issue_instr), 64'hB3);
        cycle();
        idle(); bus.flush = 1; cycle();

        // Same-cycle CDB at dispatch
        idle(); disp(32'hD0, 7'h06, 7'h20, 0, 32'h0, 7'h01, 1, 32'h3); cdb(0, 7'h20, 32'h55); cycle();
        idle(); #1;
`ifdef RS_CDB_BYPASS_EN
        chk("bypass_valid", 64'(bus.issue_valid), 64'd1);
        chk("bypass_rs1", 64'(bus.issue_rs1_data), 64'h55);
`else
        chk("nobypass_valid", 64'(bus.issue_valid), 64'd0);
`endif
        bus.flush = 1; cycle();

        // Randomized traffic with a mid-run asynchronous reset
        for (int n = 0; n < 400; n++) begin
            idle();
            if ($urandom_range(0, 1) == 1)
                disp($urandom, TW'($urandom_range(0, 127)),
                     TW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom,
                     TW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom);
            for (int c = 0; c < NC; c++)
                if ($urandom_range(0, 1) == 1) cdb(c, TW'($urandom_range(0, 7)), $urandom);
            bus.issue_ready = 1'($urandom_range(0, 1));
            bus.flush = ($urandom_range(0, 31) == 0);
            if (n == 200) begin
                idle();
                #2 reset = 1'b0;
                #1;
                chk("arst_issue_valid", 64'(bus.issue_valid), 64'd0);
                chk("arst_occupancy", 64'(bus.occupancy), 64'd0);
                model_clear();
                @(negedge clock); #1 reset = 1'b1;
                @(posedge clock); #1;
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the bench always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
